instr_fetch_unit: RTL and testbench

- Upstream fetch stage for the 16-bit multi-cycle CPU.
- Holds the program counter and, on request from the CPU control FSM's fetch state, reads one 16-bit instruction from instruction memory over a req/ack handshake.
- Latches the result into the instruction register and exports PC_out/IR_out to the CPU and the top-level debug outputs.
- Applies branch/jump redirects and flags memory timeouts.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one 16-bit word per request
// over a req/ack memory handshake, applies branch/jump redirects and raises a
// sticky fault when memory fails to answer within TIMEOUT cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no fetch outstanding; accepts redirects and fetch requests
// ST_WAIT | imem_req held high at imem_addr until ack or timeout
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_out,
    output logic [15:0] IR_out,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [15:0] r_pc,         w_pc_nxt;
    logic [15:0] r_ir,         w_ir_nxt;
    logic        r_ir_valid,   w_ir_valid_nxt;
    logic [15:0] r_addr,       w_addr_nxt;
    logic        r_fault,      w_fault_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [15:0] r_pend_pc,    w_pend_pc_nxt;
    logic [7:0]  r_cnt,        w_cnt_nxt;
    logic [7:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    // Next-state and next-register computation for the fetch handshake
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ir_nxt         = r_ir;
        w_ir_valid_nxt   = 1'b0;
        w_addr_nxt       = r_addr;
        w_fault_nxt      = r_fault;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_cnt_nxt        = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (pc_load) begin
                    w_pc_nxt = pc_target;
                end
                // A redirect in the same cycle as the request steers the fetch.
                if (fetch_req && !r_fault) begin
                    w_addr_nxt       = pc_load ? pc_target : r_pc;
                    w_cnt_nxt        = 8'd0;
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Redirects during a fetch are parked; the newest one wins.
                if (pc_load) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_pc_nxt    = pc_target;
                end
                if (imem_ack) begin
                    w_ir_nxt         = imem_rdata;
                    w_ir_valid_nxt   = 1'b1;
                    if (pc_load) begin
                        w_pc_nxt = pc_target;
                    end else if (r_pend_valid) begin
                        w_pc_nxt = r_pend_pc;
                    end else begin
                        w_pc_nxt = r_addr + PC_STEP;
                    end
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        w_fault_nxt = 1'b1;
                        if (pc_load) begin
                            w_pc_nxt = pc_target;
                        end else if (r_pend_valid) begin
                            w_pc_nxt = r_pend_pc;
                        end
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_ir         <= 16'h0000;
            r_ir_valid   <= 1'b0;
            r_addr       <= RESET_PC;
            r_fault      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 16'h0000;
            r_cnt        <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ir         <= w_ir_nxt;
            r_ir_valid   <= w_ir_valid_nxt;
            r_addr       <= w_addr_nxt;
            r_fault      <= w_fault_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign imem_req  = (r_state == ST_WAIT);
    assign busy      = (r_state == ST_WAIT);
    assign imem_addr = r_addr;
    assign PC_out    = r_pc;
    assign IR_out    = r_ir;
    assign ir_valid  = r_ir_valid;
    assign fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written timeout and
// reset-abort sequences, then random traffic against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] PC_out;
    logic [15:0] IR_out;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .RESET_PC(16'h0000),
        .PC_STEP (16'd1),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .PC_out    (PC_out),
        .IR_out    (IR_out),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        fr;
        logic        pl;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] rd;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic        e_v;
        logic        e_busy;
        logic        e_fault;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, f, l, input logic [15:0] t,
                                input logic a, input logic [15:0] d,
                                input logic q, input logic [15:0] ad, pc, ir,
                                input logic v, b, flt);
        vec_t x;
        x.rst = r; x.fr = f; x.pl = l; x.tgt = t; x.ack = a; x.rd = d;
        x.e_req = q; x.e_addr = ad; x.e_pc = pc; x.e_ir = ir;
        x.e_v = v; x.e_busy = b; x.e_fault = flt;
        return x;
    endfunction

    task automatic drive(input logic r, f, l, input logic [15:0] t,
                         input logic a, input logic [15:0] d);
        rst = r; fetch_req = f; pc_load = l; pc_target = t;
        imem_ack = a; imem_rdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic q, input logic [15:0] ad,
                       input logic [15:0] pc, input logic [15:0] ir,
                       input logic v, input logic b, input logic flt);
        n_vec++;
        if (imem_req !== q || imem_addr !== ad || PC_out !== pc || IR_out !== ir ||
            ir_valid !== v || busy !== b || fault !== flt) begin
            n_err++;
            $display("FAIL %s: got req=%b addr=%h pc=%h ir=%h v=%b busy=%b fault=%b, want req=%b addr=%h pc=%h ir=%h v=%b busy=%b fault=%b",
                     nm, imem_req, imem_addr, PC_out, IR_out, ir_valid, busy, fault,
                     q, ad, pc, ir, v, b, flt);
        end
    endtask

    // Transaction-level reference model
    int  m_pc, m_ir, m_addr, m_pend, m_waited;
    bit  m_inflight, m_valid, m_fault;

    task automatic model_step(input logic r, f, l, input logic [15:0] t,
                              input logic a, input logic [15:0] d);
        m_valid = 0;
        if (r) begin
            m_pc = 0; m_ir = 0; m_addr = 0; m_pend = -1; m_waited = 0;
            m_inflight = 0; m_fault = 0;
        end else if (!m_inflight) begin
            if (l) m_pc = int'(t);
            if (f && !m_fault) begin
                m_addr = m_pc; m_inflight = 1; m_waited = 0; m_pend = -1;
            end
        end else begin
            if (l) m_pend = int'(t);
            if (a) begin
                m_ir = int'(d);
                m_valid = 1;
                m_pc = (m_pend >= 0) ? m_pend : (m_addr + 1) % 65536;
                m_pend = -1;
                m_inflight = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_fault = 1;
                    m_inflight = 0;
                    if (m_pend >= 0) m_pc = m_pend;
                    m_pend = -1;
                end
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 0, 16'h0);

        //            rst fr pl tgt      ack rd        req addr     pc       ir       v  b  f
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 16'h0001, 16'h1234, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0001, 16'h1234, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h1234, 0, 1, 0);
        vecs[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h1234, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h1234, 0, 1, 0);
        vecs[7]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h1234, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 16'h0000, 1, 16'hABCD, 0, 16'h0001, 16'h0002, 16'hABCD, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'h0002, 16'hABCD, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 16'h0040, 16'hABCD, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0040, 16'h0041, 16'h1111, 1, 0, 0);
        vecs[12] = mk(0, 0, 1, 16'h0005, 0, 16'h0000, 0, 16'h0040, 16'h0005, 16'h1111, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 16'h0005, 16'h1111, 0, 1, 0);
        vecs[14] = mk(0, 0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0005, 16'h0005, 16'h1111, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 16'h0000, 1, 16'h2222, 0, 16'h0005, 16'h0100, 16'h2222, 1, 0, 0);
        vecs[16] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 16'h0100, 16'h2222, 0, 1, 0);
        vecs[17] = mk(0, 0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0100, 16'h0100, 16'h2222, 0, 1, 0);
        vecs[18] = mk(0, 0, 1, 16'h0300, 1, 16'h3333, 0, 16'h0100, 16'h0300, 16'h3333, 1, 0, 0);
        vecs[19] = mk(0, 0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0100, 16'hFFFF, 16'h3333, 0, 0, 0);
        vecs[20] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 16'h3333, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 16'h0000, 1, 16'h4444, 0, 16'hFFFF, 16'h0000, 16'h4444, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 16'h0000, 1, 16'h5555, 0, 16'hFFFF, 16'h0000, 16'h4444, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].fr, vecs[i].pl, vecs[i].tgt, vecs[i].ack, vecs[i].rd);
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc,
                vecs[i].e_ir, vecs[i].e_v, vecs[i].e_busy, vecs[i].e_fault);
        end

        // Timeout: fetch at PC 0 never acknowledged
        drive(0, 1, 0, 16'h0, 0, 16'h0);
        step();
        chk("to_start", 1, 16'h0000, 16'h0000, 16'h4444, 0, 1, 0);
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            chk($sformatf("to_wait%0d", i), 1, 16'h0000, 16'h0000, 16'h4444, 0, 1, 0);
        end
        step();
        chk("to_fault", 0, 16'h0000, 16'h0000, 16'h4444, 0, 0, 1);
        drive(0, 1, 0, 16'h0, 0, 16'h0);
        step();
        chk("to_fetch_ignored", 0, 16'h0000, 16'h0000, 16'h4444, 0, 0, 1);
        drive(0, 0, 0, 16'h0, 1, 16'h9999);
        step();
        chk("to_late_ack", 0, 16'h0000, 16'h0000, 16'h4444, 0, 0, 1);
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        step();
        chk("to_rst_clears", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        // Reset mid-fetch abandons the fetch; following ack ignored
        drive(0, 0, 1, 16'h0020, 0, 16'h0);
        step();
        drive(0, 1, 0, 16'h0, 0, 16'h0);
        step();
        chk("abort_start", 1, 16'h0020, 16'h0020, 16'h0000, 0, 1, 0);
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        step();
        chk("abort_rst", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 0, 0, 16'h0, 1, 16'h7777);
        step();
        chk("abort_late_ack", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        // Random traffic against the model
        model_step(1, 0, 0, 16'h0, 0, 16'h0);
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        step();
        for (int i = 0; i < 3000; i++) begin
            logic r, f, l, a;
            logic [15:0] t, d;
            r = ($urandom % 120) == 0;
            f = ($urandom % 3) == 0;
            l = ($urandom % 8) == 0;
            a = ($urandom % 4) == 0;
            t = 16'($urandom);
            d = 16'($urandom);
            if (($urandom % 10) == 0) t = 16'hFFFF;
            drive(r, f, l, t, a, d);
            model_step(r, f, l, t, a, d);
            step();
            chk($sformatf("rand%0d", i), m_inflight, 16'(m_addr), 16'(m_pc), 16'(m_ir),
                m_valid, m_inflight, m_fault);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
